// File: rtl/ddr3_mem_tester.sv
// Avalon-MM traffic generator for the DDR3 EMIF local port: writes a seeded address pattern
// over a word range, reads it back in order, and reports pass/fail and mismatch statistics.
module ddr3_mem_tester #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] SEED        = 32'hA5C3_1E0F,
  parameter int unsigned MAX_OUTST   = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                start,
  input  logic                local_init_done,
  input  logic                local_cal_success,
  input  logic                local_cal_fail,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  // Word counters need one extra bit so NUM_WORDS = 2^ADDR_W is representable.
  localparam int unsigned CW = ADDR_W + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0]     LAST    = CW'(NUM_WORDS);
  localparam logic [CW-1:0]     LAST_M1 = CW'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [OW-1:0]     MAX_O   = OW'(MAX_OUTST);

  typedef enum logic [2:0] {StIdle, StWaitCal, StWrite, StRead, StDone} state_e;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = SEED ^ 32'(a);
    return {(DATA_W/32){w}};
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ferr_q, ferr_d, cmp_addr_q, cmp_addr_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, chk_cnt_q, chk_cnt_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              cmp_vld_q, cmp_vld_d, cmp_err_q, cmp_err_d;
  logic              cmp_lat_q, cmp_lat_d, cmp_last_q, cmp_last_d;
  logic [15:0]       err_q, err_d;
  logic              ferr_seen_q, ferr_seen_d, calf_q, calf_d, tmo_flag_q, tmo_flag_d;
  logic              done_q, done_d, pass_q, pass_d, busy_q, busy_d;

  logic              rd_acc, active, rdv_ok, rdv_stray;
  logic [ADDR_W-1:0] chk_addr;

  // Next-state logic: FSM, command issue, registered compare stage and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    err_d       = err_q;
    ferr_d      = ferr_q;
    ferr_seen_d = ferr_seen_q;
    calf_d      = calf_q;
    tmo_flag_d  = tmo_flag_q;
    done_d      = done_q;
    pass_d      = pass_q;

    rd_acc    = rd_q & ~avm_waitrequest;
    active    = (state_q == StWrite) || (state_q == StRead);
    rdv_ok    = avm_readdatavalid & (outst_q != '0);
    rdv_stray = avm_readdatavalid & (outst_q == '0);
    chk_addr  = BASE + chk_cnt_q[ADDR_W-1:0];
    outst_d   = outst_q + OW'(rd_acc) - OW'(rdv_ok);

    // Compare stage; a stray return is an error that never names a failing address.
    cmp_vld_d  = avm_readdatavalid & active;
    cmp_err_d  = rdv_stray | (avm_readdata != pattern(chk_addr));
    cmp_lat_d  = rdv_ok;
    cmp_addr_d = chk_addr;
    cmp_last_d = rdv_ok & active & (chk_cnt_q == LAST_M1);
    if (rdv_ok && active) chk_cnt_d = chk_cnt_q + 1'b1;

    if (cmp_vld_q && cmp_err_q) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (cmp_lat_q && !ferr_seen_q) begin
        ferr_d      = cmp_addr_q;
        ferr_seen_d = 1'b1;
      end
    end

    if (state_q == StRead && outst_q != '0 && !avm_readdatavalid) tmo_d = tmo_q + 32'd1;
    else tmo_d = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StWaitCal;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          chk_cnt_d   = '0;
          outst_d     = '0;
          tmo_d       = '0;
          err_d       = '0;
          ferr_d      = '0;
          ferr_seen_d = 1'b0;
          calf_d      = 1'b0;
          tmo_flag_d  = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end
      end
      StWaitCal: begin
        if (local_cal_fail) begin
          calf_d  = 1'b1;
          state_d = StDone;
        end else if (local_init_done && local_cal_success) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!wr_q || !avm_waitrequest) begin
          if (wr_cnt_q != LAST) begin
            wr_d     = 1'b1;
            addr_d   = BASE + wr_cnt_q[ADDR_W-1:0];
            wdata_d  = pattern(addr_d);
            wr_cnt_d = wr_cnt_q + 1'b1;
          end else begin
            wr_d    = 1'b0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        // Gate on the post-update count so a held read can never push past MAX_OUTST.
        if (!rd_q || !avm_waitrequest) begin
          if (rd_cnt_q != LAST && outst_d < MAX_O) begin
            rd_d     = 1'b1;
            addr_d   = BASE + rd_cnt_q[ADDR_W-1:0];
            rd_cnt_d = rd_cnt_q + 1'b1;
          end else begin
            rd_d = 1'b0;
          end
        end
        if (cmp_vld_q && cmp_last_q) begin
          state_d = StDone;
        end else if (tmo_d == TIMEOUT_CYC) begin
          tmo_flag_d = 1'b1;
          state_d    = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StDone && state_q != StDone) begin
      rd_d   = 1'b0;
      wr_d   = 1'b0;
      done_d = 1'b1;
      pass_d = (err_d == 16'd0) & ~tmo_flag_d & ~calf_d;
    end
    busy_d = (state_d == StWaitCal) || (state_d == StWrite) || (state_d == StRead);
  end

  // State register with synchronous reset; reset aborts any test in progress.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      chk_cnt_q   <= '0;
      outst_q     <= '0;
      tmo_q       <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_err_q   <= 1'b0;
      cmp_lat_q   <= 1'b0;
      cmp_last_q  <= 1'b0;
      cmp_addr_q  <= '0;
      err_q       <= '0;
      ferr_q      <= '0;
      ferr_seen_q <= 1'b0;
      calf_q      <= 1'b0;
      tmo_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      chk_cnt_q   <= chk_cnt_d;
      outst_q     <= outst_d;
      tmo_q       <= tmo_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_err_q   <= cmp_err_d;
      cmp_lat_q   <= cmp_lat_d;
      cmp_last_q  <= cmp_last_d;
      cmp_addr_q  <= cmp_addr_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      ferr_seen_q <= ferr_seen_d;
      calf_q      <= calf_d;
      tmo_flag_q  <= tmo_flag_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = '1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = tmo_flag_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_ddr3_mem_tester.sv
// Self-checking bench for ddr3_mem_tester: behavioural EMIF slave, scoreboard queues filled by
// the stimulus and drained by an independent bus/result monitor.
module tb_ddr3_mem_tester;
  localparam int unsigned AW   = 25;
  localparam int unsigned DW   = 64;
  localparam int unsigned NW   = 16;
  localparam int unsigned BASE = 32'h01FF_FFFC;
  localparam logic [31:0] SEED = 32'hA5C3_1E0F;

  logic          clk_clk = 1'b0;
  logic          reset_reset, start, local_init_done, local_cal_success, local_cal_fail;
  logic [AW-1:0] avm_address, first_err_addr;
  logic          avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic [7:0]    avm_byteenable;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;

  always #5 clk_clk = ~clk_clk;

  ddr3_mem_tester #(
    .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .NUM_WORDS(NW), .SEED(SEED),
    .MAX_OUTST(8), .TIMEOUT_CYC(4096)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start),
    .local_init_done(local_init_done), .local_cal_success(local_cal_success),
    .local_cal_fail(local_cal_fail), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wexp_t;
  typedef struct {logic p; logic [15:0] err; logic [AW-1:0] ferr; logic tmo;} res_t;
  typedef struct {int due; logic [DW-1:0] data; logic [AW-1:0] addr;} rrec_t;

  wexp_t         exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  res_t          exp_res[$];
  rrec_t         pend[$];
  logic [DW-1:0] mem [32];

  int n_checks = 0, n_errors = 0;
  int n_wr = 0, n_rd = 0, res_seen = 0, outst_m = 0, mcyc = 0, last_rdv = 0, done_cyc = 0;
  int unsigned   wait_pct = 0;
  int            rd_lat = 2, drop_n = -1, ret_idx = 0, scyc = 0;
  bit            flip_en = 0;
  logic [AW-1:0] flip_addr = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [31:0] w;
    w = SEED ^ {7'd0, a};
    return {w, w};
  endfunction

  function automatic logic [AW-1:0] waddr(input int i);
    logic [AW-1:0] b;
    b = AW'(BASE);
    return b + AW'(i);
  endfunction

  // Behavioural EMIF slave: random stall, fixed read latency, optional corrupt/drop of returns.
  initial begin
    rrec_t r;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clk_clk);
      scyc++;
      avm_readdatavalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= scyc) begin
        r = pend.pop_front();
        if (ret_idx != drop_n) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = r.data ^ ((flip_en && r.addr == flip_addr) ? 64'd1 : 64'd0);
        end
        ret_idx++;
      end
      avm_waitrequest = ($urandom_range(99) < wait_pct);
      if (!avm_waitrequest) begin
        if (avm_write) mem[avm_address[4:0]] = avm_writedata;
        if (avm_read) pend.push_back('{scyc + rd_lat, mem[avm_address[4:0]], avm_address});
      end
    end
  end

  // Monitor: checks accepted commands and final results against the scoreboard queues.
  initial begin
    logic       stall_prev, done_prev, prd, pwr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdata;
    wexp_t w;
    res_t  r;
    stall_prev = 0; done_prev = 0; prd = 0; pwr = 0; paddr = '0; pdata = '0;
    forever begin
      @(negedge clk_clk); #1;
      mcyc++;
      if (!reset_reset) begin
        if (stall_prev) begin
          chk("stall_read", avm_read, prd);
          chk("stall_write", avm_write, pwr);
          chk("stall_addr", avm_address, paddr);
          chk("stall_wdata", avm_writedata, pdata);
        end
        if ((avm_read || avm_write) && !avm_waitrequest)
          chk("rd_wr_excl", avm_read & avm_write, 0);
        if (avm_write && !avm_waitrequest) begin
          n_wr++;
          if (exp_wr.size() == 0) chk("unexpected_write", avm_address, 128'hX);
          else begin
            w = exp_wr.pop_front();
            chk("wr_addr", avm_address, w.addr);
            chk("wr_data", avm_writedata, w.data);
          end
        end
        if (avm_readdatavalid) begin
          if (outst_m > 0) outst_m--;
          last_rdv = mcyc;
        end
        if (avm_read && !avm_waitrequest) begin
          n_rd++;
          outst_m++;
          chk("max_outst", outst_m > 8, 0);
          if (exp_rd.size() == 0) chk("unexpected_read", avm_address, 128'hX);
          else chk("rd_addr", avm_address, exp_rd.pop_front());
        end
        if (done && !done_prev) begin
          done_cyc = mcyc;
          if (exp_res.size() == 0) chk("unexpected_done", done, 0);
          else begin
            r = exp_res.pop_front();
            chk("res_pass", pass, r.p);
            chk("res_err_count", err_count, r.err);
            chk("res_first_err_addr", first_err_addr, r.ferr);
            chk("res_timeout", timeout, r.tmo);
            chk("res_busy", busy, 0);
          end
          res_seen++;
        end
      end
      done_prev  = done;
      stall_prev = !reset_reset && (avm_read || avm_write) && avm_waitrequest;
      prd = avm_read; pwr = avm_write; paddr = avm_address; pdata = avm_writedata;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_address"}, avm_address, 0);
    chk({tag, "_read"}, avm_read, 0);
    chk({tag, "_write"}, avm_write, 0);
    chk({tag, "_writedata"}, avm_writedata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_err_addr"}, first_err_addr, 0);
  endtask

  task automatic run_test(input string tag, input int unsigned wp, input int lat, input bit fe,
                          input logic [AW-1:0] fa, input int dn, input bit calf, input res_t r,
                          input int budget);
    int n, wr0, rd0, seen0;
    wait_pct = wp; rd_lat = lat; flip_en = fe; flip_addr = fa; drop_n = dn; ret_idx = 0;
    if (!calf) begin
      for (int i = 0; i < int'(NW); i++) exp_wr.push_back('{waddr(i), pat(waddr(i))});
      for (int i = 0; i < int'(NW); i++) exp_rd.push_back(waddr(i));
    end
    exp_res.push_back(r);
    wr0 = n_wr; rd0 = n_rd; seen0 = res_seen; outst_m = 0;
    local_cal_fail = calf; local_cal_success = !calf;
    @(negedge clk_clk); start = 1'b1;
    @(negedge clk_clk); start = 1'b0;
    #1;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_done_cleared"}, done, 0);
    n = 1;
    while (res_seen == seen0 && n < budget) begin
      @(negedge clk_clk); #2;
      n++;
    end
    chk({tag, "_finished"}, res_seen != seen0, 1);
    if (calf) chk({tag, "_cal_fail_latency_le2"}, n <= 2, 1);
    chk({tag, "_write_count"}, n_wr - wr0, calf ? 0 : NW);
    chk({tag, "_read_count"}, n_rd - rd0, calf ? 0 : NW);
    chk({tag, "_wr_queue_drained"}, exp_wr.size(), 0);
    chk({tag, "_rd_queue_drained"}, exp_rd.size(), 0);
    exp_wr.delete(); exp_rd.delete(); exp_res.delete();
    local_cal_fail = 1'b0; local_cal_success = 1'b1;
  endtask

  initial begin
    int n, wr0;
    reset_reset = 1'b1; start = 1'b0;
    local_init_done = 1'b1; local_cal_success = 1'b1; local_cal_fail = 1'b0;
    repeat (3) @(negedge clk_clk);
    #1;
    chk_zero("reset");
    chk("byteenable", avm_byteenable, 8'hFF);
    @(negedge clk_clk); reset_reset = 1'b0;

    // Ideal slave across the address wrap 1FFFFFC..1FFFFFF, 0..B.
    run_test("t1_ideal", 0, 2, 0, '0, -1, 0, '{1'b1, 16'd0, 25'd0, 1'b0}, 2000);
    run_test("t2_flip5", 0, 2, 1, 25'd5, -1, 0, '{1'b0, 16'd1, 25'd5, 1'b0}, 2000);
    run_test("t3_stall", 50, 20, 0, '0, -1, 0, '{1'b1, 16'd0, 25'd0, 1'b0}, 4000);
    run_test("t4_calfail", 0, 2, 0, '0, -1, 1, '{1'b0, 16'd0, 25'd0, 1'b0}, 50);
    // Third return dropped: words 2..14 compare against shifted data, then the last read times out.
    run_test("t5_drop", 0, 2, 0, '0, 2, 0, '{1'b0, 16'd13, 25'h1FF_FFFE, 1'b1}, 8000);
    chk("t5_timeout_gap", done_cyc - last_rdv, 4097);

    // Reset in the middle of the write phase.
    wait_pct = 0; drop_n = -1; flip_en = 0;
    for (int i = 0; i < int'(NW); i++) exp_wr.push_back('{waddr(i), pat(waddr(i))});
    wr0 = n_wr;
    @(negedge clk_clk); start = 1'b1;
    @(negedge clk_clk); start = 1'b0;
    n = 0;
    while (n_wr - wr0 < 3 && n < 100) begin
      @(negedge clk_clk); #2;
      n++;
    end
    chk("t6_writes_started", n_wr - wr0 >= 3, 1);
    reset_reset = 1'b1;
    @(negedge clk_clk); #1;
    chk_zero("t6_mid_reset");
    reset_reset = 1'b0;
    exp_wr.delete(); exp_rd.delete(); exp_res.delete();

    run_test("t7_after_reset", 0, 2, 0, '0, -1, 0, '{1'b1, 16'd0, 25'd0, 1'b0}, 2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
             n_checks, n_errors);
    $fatal(1);
  end

endmodule
